// File: rtl/data_sram_like_bridge.sv
// data_sram_like_bridge
// Data-side adapter between the M-stage memory port and an SRAM-like bus
// (req / addr_ok / data_ok). One transaction is outstanding at a time. The
// pipeline is stalled until the read data (or write completion) comes back,
// and the returned word is held in a register for the load unit.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   cpu_en            : M-stage instruction accesses memory
//   cpu_wen[3:0]      : byte enables (0000 = load)
//   cpu_addr[31:0]    : word address from the core (bits [1:0] ignored)
//   cpu_wdata[31:0]   : lane-replicated store data
//   cpu_stall_other   : pipeline held by some other unit
//   cpu_rdata[31:0]   : latched read word
//   cpu_stall         : memory-side stall request
//   data_req/wr/size/addr/wdata : bus request fields
//   data_addr_ok, data_data_ok, data_rdata : bus responses
module data_sram_like_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_stall_other,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t      stateR;
    logic        reqWrR;
    logic [1:0]  reqSizeR;
    logic [31:0] reqAddrR;
    logic [31:0] reqWdataR;
    logic [31:0] rdataR;

    logic [3:0]  decS;
    logic        curWrS;
    logic [1:0]  curSizeS;
    logic [31:0] curAddrS;

    // Byte-enable pattern -> {size, addr[1:0]}; unknown patterns become word writes.
    function automatic logic [3:0] decodeWen(input logic [3:0] wen);
        case (wen)
            4'b0001: decodeWen = {2'd0, 2'd0};
            4'b0010: decodeWen = {2'd0, 2'd1};
            4'b0100: decodeWen = {2'd0, 2'd2};
            4'b1000: decodeWen = {2'd0, 2'd3};
            4'b0011: decodeWen = {2'd1, 2'd0};
            4'b1100: decodeWen = {2'd1, 2'd2};
            default: decodeWen = {2'd2, 2'd0};
        endcase
    endfunction

    // Request fields derived live from the core inputs (used in the issue cycle).
    always_comb begin
        decS     = decodeWen(cpu_wen);
        curWrS   = |cpu_wen;
        curSizeS = decS[3:2];
        curAddrS = {cpu_addr[31:2], decS[1:0]};
    end

    // Bus request outputs: live in IDLE, from the captured copies afterwards.
    // Reset gates everything so the request drops the moment rst goes low.
    always_comb begin
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        if (!rst) begin
            data_req = 1'b0;
        end else begin
            case (stateR)
                IDLE: begin
                    if (cpu_en) begin
                        data_req   = 1'b1;
                        data_wr    = curWrS;
                        data_size  = curSizeS;
                        data_addr  = curAddrS;
                        data_wdata = cpu_wdata;
                    end else begin
                        data_req = 1'b0;
                    end
                end
                WAIT_ADDR: begin
                    // Never withdrawn before addr_ok, even if cpu_en drops.
                    data_req   = 1'b1;
                    data_wr    = reqWrR;
                    data_size  = reqSizeR;
                    data_addr  = reqAddrR;
                    data_wdata = reqWdataR;
                end
                WAIT_DATA, DONE: begin
                    data_req   = 1'b0;
                    data_wr    = reqWrR;
                    data_size  = reqSizeR;
                    data_addr  = reqAddrR;
                    data_wdata = reqWdataR;
                end
                default: begin
                    data_req = 1'b0;
                end
            endcase
        end
    end

    // Core-facing outputs: stall until DONE, read data from the capture register.
    always_comb begin
        cpu_stall = rst & cpu_en & (stateR != DONE);
        cpu_rdata = rdataR;
    end

    // Transaction FSM, request-field capture and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateR    <= IDLE;
            reqWrR    <= 1'b0;
            reqSizeR  <= 2'd0;
            reqAddrR  <= 32'd0;
            reqWdataR <= 32'd0;
            rdataR    <= 32'd0;
        end else begin
            case (stateR)
                IDLE: begin
                    if (cpu_en) begin
                        reqWrR    <= curWrS;
                        reqSizeR  <= curSizeS;
                        reqAddrR  <= curAddrS;
                        reqWdataR <= cpu_wdata;
                        if (data_addr_ok && data_data_ok) begin
                            stateR <= DONE;
                            rdataR <= data_rdata;
                        end else if (data_addr_ok) begin
                            stateR <= WAIT_DATA;
                        end else begin
                            stateR <= WAIT_ADDR;
                        end
                    end
                end
                WAIT_ADDR: begin
                    if (data_addr_ok && data_data_ok) begin
                        stateR <= DONE;
                        rdataR <= data_rdata;
                    end else if (data_addr_ok) begin
                        stateR <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (data_data_ok) begin
                        stateR <= DONE;
                        rdataR <= data_rdata;
                    end
                end
                DONE: begin
                    // Stay here (no reissue) while the pipeline is held elsewhere.
                    if (!cpu_stall_other) begin
                        stateR <= IDLE;
                    end
                end
                default: begin
                    stateR <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
module tb_data_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall_other;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_sram_like_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_en          (cpu_en),
        .cpu_wen         (cpu_wen),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_stall_other (cpu_stall_other),
        .cpu_rdata       (cpu_rdata),
        .cpu_stall       (cpu_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
    );

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        chkFields;
        logic        expReq;
        logic        expWr;
        logic [1:0]  expSize;
        logic [31:0] expAddr;
        logic        expStall;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: single enabled lane -> byte at that lane; the two aligned
    // halfword pairs -> halfword; anything else -> full word at offset 0.
    function automatic void refDecode(input logic [3:0] wen, output logic [1:0] sz, output logic [1:0] lo);
        int ones;
        ones = $countones(wen);
        sz = 2'd2;
        lo = 2'd0;
        if (ones == 1) begin
            sz = 2'd0;
            for (int i = 0; i < 4; i++) if (wen[i]) lo = 2'(i);
        end else if (wen == 4'b0011 || wen == 4'b1100) begin
            sz = 2'd1;
            lo = wen[2] ? 2'd2 : 2'd0;
        end
    endfunction

    // One full access: slave answers addr_ok after aDly request cycles and
    // data_ok dDly cycles after that; stall_other holds DONE for sOth cycles.
    task automatic runTxn(input string nm, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wd, input int aDly, input int dDly,
                          input int sOth, input logic [31:0] rd);
        int cycles;
        int stallCnt;
        int reqCnt;
        int fieldBad;
        int rdBad;
        int doneAt;
        logic [1:0]  sz;
        logic [1:0]  lo;
        logic [31:0] expAddr;
        refDecode(wen, sz, lo);
        expAddr  = {addr[31:2], lo};
        doneAt   = aDly + dDly + 1;
        cycles   = doneAt + sOth + 1;
        stallCnt = 0;
        reqCnt   = 0;
        fieldBad = 0;
        rdBad    = 0;
        for (int c = 0; c < cycles; c++) begin
            cpu_en          = 1'b1;
            cpu_wen         = wen;
            cpu_addr        = addr;
            cpu_wdata       = wd;
            data_addr_ok    = (c == aDly);
            data_data_ok    = (c == aDly + dDly);
            data_rdata      = (c == aDly + dDly) ? rd : $urandom;
            cpu_stall_other = (c >= doneAt) && (c < doneAt + sOth);
            @(negedge clk);
            if (cpu_stall) stallCnt++;
            if (data_req) begin
                reqCnt++;
                if (data_wr !== (|wen) || data_size !== sz || data_addr !== expAddr || data_wdata !== wd)
                    fieldBad++;
            end
            if (c >= doneAt && cpu_rdata !== rd) rdBad++;
            @(posedge clk);
            #1;
        end
        data_addr_ok    = 1'b0;
        data_data_ok    = 1'b0;
        cpu_stall_other = 1'b0;
        chk({nm, " stall cycles"}, 32'(stallCnt), 32'(aDly + dDly + 1));
        chk({nm, " req cycles"},   32'(reqCnt),   32'(aDly + 1));
        chk({nm, " field errs"},   32'(fieldBad), 32'd0);
        chk({nm, " rdata errs"},   32'(rdBad),    32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'b0000, 32'h00001000, 32'h01010101, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 2'd2, 32'h00001000, 1'b1};
        vecs[1]  = '{1'b1, 4'b0001, 32'h00002003, 32'h22222222, 32'h00000001, 1'b1, 1'b1, 1'b1, 2'd0, 32'h00002000, 1'b1};
        vecs[2]  = '{1'b1, 4'b0010, 32'h10000000, 32'h33333333, 32'h00000002, 1'b1, 1'b1, 1'b1, 2'd0, 32'h10000001, 1'b1};
        vecs[3]  = '{1'b1, 4'b0100, 32'h80001000, 32'h44444444, 32'h00000003, 1'b1, 1'b1, 1'b1, 2'd0, 32'h80001002, 1'b1};
        vecs[4]  = '{1'b1, 4'b1000, 32'h0000ABC0, 32'h55555555, 32'h00000004, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0000ABC3, 1'b1};
        vecs[5]  = '{1'b1, 4'b0011, 32'h12345678, 32'h66666666, 32'h00000005, 1'b1, 1'b1, 1'b1, 2'd1, 32'h12345678, 1'b1};
        vecs[6]  = '{1'b1, 4'b1100, 32'h12345675, 32'h77777777, 32'h00000006, 1'b1, 1'b1, 1'b1, 2'd1, 32'h12345676, 1'b1};
        vecs[7]  = '{1'b1, 4'b1111, 32'hFFFFFFFF, 32'h88888888, 32'h00000007, 1'b1, 1'b1, 1'b1, 2'd2, 32'hFFFFFFFC, 1'b1};
        vecs[8]  = '{1'b1, 4'b0101, 32'h00000011, 32'h99999999, 32'h00000008, 1'b1, 1'b1, 1'b1, 2'd2, 32'h00000010, 1'b1};
        vecs[9]  = '{1'b0, 4'b0000, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 4'b1100, 32'h66666666, 32'hBBBBBBBB, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00000000, 1'b0};

        rst             = 1'b0;
        cpu_en          = 1'b0;
        cpu_wen         = 4'b0000;
        cpu_addr        = 32'd0;
        cpu_wdata       = 32'd0;
        cpu_stall_other = 1'b0;
        data_addr_ok    = 1'b0;
        data_data_ok    = 1'b0;
        data_rdata      = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst req",   32'(data_req),  32'd0);
        chk("rst wr",    32'(data_wr),   32'd0);
        chk("rst size",  32'(data_size), 32'd0);
        chk("rst addr",  data_addr,      32'd0);
        chk("rst wdata", data_wdata,     32'd0);
        chk("rst rdata", cpu_rdata,      32'd0);
        chk("rst stall", 32'(cpu_stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Table: single-cycle (addr_ok+data_ok in issue cycle) accesses
        for (int i = 0; i < 11; i++) begin
            cpu_en          = vecs[i].en;
            cpu_wen         = vecs[i].wen;
            cpu_addr        = vecs[i].addr;
            cpu_wdata       = vecs[i].wdata;
            data_addr_ok    = vecs[i].en;
            data_data_ok    = vecs[i].en;
            data_rdata      = vecs[i].rd;
            cpu_stall_other = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d req", i),   32'(data_req),  32'(vecs[i].expReq));
            chk($sformatf("tbl%0d stall", i), 32'(cpu_stall), 32'(vecs[i].expStall));
            if (vecs[i].chkFields) begin
                chk($sformatf("tbl%0d wr", i),    32'(data_wr),   32'(vecs[i].expWr));
                chk($sformatf("tbl%0d size", i),  32'(data_size), 32'(vecs[i].expSize));
                chk($sformatf("tbl%0d addr", i),  data_addr,      vecs[i].expAddr);
                chk($sformatf("tbl%0d wdata", i), data_wdata,     vecs[i].wdata);
            end
            @(posedge clk);
            #1;
            if (vecs[i].en) begin
                data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
                data_rdata   = 32'h0BAD0BAD;
                @(negedge clk);
                chk($sformatf("tbl%0d done rdata", i), cpu_rdata,      vecs[i].rd);
                chk($sformatf("tbl%0d done stall", i), 32'(cpu_stall), 32'd0);
                chk($sformatf("tbl%0d done req", i),   32'(data_req),  32'd0);
                @(posedge clk);
                #1;
            end
        end
        cpu_en = 1'b0;
        @(posedge clk);
        #1;

        // Directed multi-cycle cases
        runTxn("ld best", 4'b0000, 32'h00000100, 32'h0, 0, 0, 0, 32'hDEADBEEF);
        runTxn("sb wait addr", 4'b0100, 32'h80001000, 32'hCAFEF00D, 3, 0, 0, 32'h13579BDF);
        runTxn("ld slow data", 4'b0000, 32'h00002000, 32'h0, 0, 5, 2, 32'h2468ACE0);
        runTxn("sh hi", 4'b1100, 32'h00003000, 32'hBEEFBEEF, 1, 1, 0, 32'h0);
        runTxn("b2b ld0", 4'b0000, 32'h00001000, 32'h0, 1, 0, 0, 32'hAAAA0000);
        runTxn("b2b ld1", 4'b0000, 32'h00001004, 32'h0, 1, 0, 0, 32'hBBBB1111);

        // Request held from captured copies when cpu_en drops in WAIT_ADDR
        cpu_en = 1'b1; cpu_wen = 4'b0001; cpu_addr = 32'h40000005; cpu_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("hold issue req", 32'(data_req), 32'd1);
        @(posedge clk);
        #1;
        cpu_en = 1'b0; cpu_wen = 4'b1111; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        @(negedge clk);
        chk("hold req",   32'(data_req),  32'd1);
        chk("hold addr",  data_addr,      32'h40000004);
        chk("hold size",  32'(data_size), 32'd0);
        chk("hold wr",    32'(data_wr),   32'd1);
        chk("hold wdata", data_wdata,     32'hA5A5A5A5);
        @(posedge clk);
        #1;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h11112222;
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        @(negedge clk);
        chk("hold done req",   32'(data_req), 32'd0);
        chk("hold done rdata", cpu_rdata,     32'h11112222);
        @(posedge clk);
        #1;

        // Reset in WAIT_DATA, then a late data_ok must be ignored
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h00003000; data_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("wdata stall", 32'(cpu_stall), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid rst req",   32'(data_req),  32'd0);
        chk("mid rst rdata", cpu_rdata,      32'd0);
        chk("mid rst stall", 32'(cpu_stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1; cpu_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h77778888;
        @(negedge clk);
        chk("late ok req", 32'(data_req), 32'd0);
        @(posedge clk);
        #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("late ok rdata", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        runTxn("post rst", 4'b0011, 32'h00004000, 32'h12341234, 2, 1, 1, 32'h5A5A5A5A);

        // Randomized accesses against the reference model
        for (int n = 0; n < 25; n++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            runTxn($sformatf("rnd%0d", n), w, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 2)), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                cpu_en = 1'b0;
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_sram_like_bridge.md
# data_sram_like_bridge

Data-side bus adapter between the pipeline's M stage and the SRAM-like data bus. It turns the core's single-cycle memory access (byte enables, word-aligned address, write data) into a req/addr_ok/data_ok transaction. It produces a stall that holds the pipeline until the access completes and presents the latched read data to the load unit. One transaction is outstanding at a time. The block sits between the core's data port and the CPU top's bus arbiter.

## Interface
Parameters:
- none; all widths fixed at 32-bit address/data, 4-bit byte enable.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_en`  in  1  M-stage instruction performs a memory access (load or store).
- `cpu_wen`  in  4  byte enables; 0000 = load; already masked to 0000 for a faulting store.
- `cpu_addr`  in  32  word-aligned physical address; bits [1:0] are ignored.
- `cpu_wdata`  in  32  store data, already lane-replicated.
- `cpu_stall_other`  in  1  pipeline held by another source (divider, hazard).
- `cpu_rdata`  out  32  latched read word for the load unit.
- `cpu_stall`  out  1  memory-side stall request to hazard unit.
- `data_req`  out  1  bus request.
- `data_wr`  out  1  1 = write.
- `data_size`  out  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  out  32  byte address.
- `data_wdata`  out  32  write data.
- `data_addr_ok`  in  1  request accepted this cycle.
- `data_data_ok`  in  1  data returned / write done this cycle.
- `data_rdata`  in  32  read data, valid with `data_data_ok`.

## Operation
- FSM states: IDLE, WAIT_ADDR, WAIT_DATA, DONE. Reset state is IDLE.
- IDLE:
  - `data_req` = `cpu_en`.
  - Both `addr_ok` and `data_ok` this cycle -> DONE.
  - `addr_ok` only -> WAIT_DATA.
  - Neither -> WAIT_ADDR if `cpu_en`, else stay IDLE.
- WAIT_ADDR:
  - `data_req` = 1, with request fields held from registered copies captured at first issue. The request is never withdrawn before `addr_ok`, even if `cpu_en` drops.
  - `addr_ok`&`data_ok` -> DONE; `addr_ok` -> WAIT_DATA.
- WAIT_DATA:
  - `data_req` = 0.
  - `data_ok` -> DONE, capturing `data_rdata` into the rdata register. Writes also capture; the value is irrelevant.
- DONE:
  - `data_req` = 0, so the access is not reissued while the pipeline is held.
  - `cpu_stall_other` = 0 -> IDLE; otherwise stay in DONE.
- `cpu_stall` = `cpu_en` & (state != DONE). When `cpu_en` = 0 in IDLE, `cpu_stall` = 0.
- `data_wr` = |`cpu_wen`.
- Size and address low bits come from `cpu_wen`:
  - 0001/0010/0100/1000 -> size 0, addr[1:0] = 0/1/2/3.
  - 0011 -> size 1, addr[1:0] = 0.
  - 1100 -> size 1, addr[1:0] = 2.
  - 1111 or 0000 (load) -> size 2, addr[1:0] = 0.
  - Any other pattern -> size 2, addr[1:0] = 0, treated as word write.
- `data_addr`[31:2] = `cpu_addr`[31:2]. `data_wdata` = `cpu_wdata`.
- `data_data_ok` outside WAIT_DATA/IDLE-issue/WAIT_ADDR-issue is a protocol violation and is ignored.

## Timing
- Reset values: `data_req` 0, `data_wr` 0, `data_size` 0, `data_addr` 0, `data_wdata` 0, `cpu_rdata` 0, `cpu_stall` 0, state IDLE. Request-field registers are 0.
- Best case: `addr_ok` and `data_ok` in the issue cycle. State is DONE the next cycle, `cpu_stall` is 1 for exactly one cycle, and `cpu_rdata` is valid in the DONE cycle.
- General case: stall cycles = cycles to `addr_ok` + cycles to `data_ok` + 1.
- `cpu_rdata` holds its value from DONE until the next `data_ok` capture.
- Request outputs in IDLE are combinational from core inputs. In WAIT_ADDR they come from registers loaded in the IDLE issue cycle.
- Reset asserted mid-transaction: return to IDLE immediately with `data_req` = 0. A late `data_ok` after release while in IDLE is ignored.
- Back-to-back accesses: DONE -> IDLE -> issue the next access in the following cycle, so there is one idle bus cycle between accesses.

## Test plan
- Load, slave answers `addr_ok`+`data_ok` in the same cycle with rdata = 0xDEADBEEF: `cpu_stall` is high 1 cycle, `data_size` = 2, and `cpu_rdata` = 0xDEADBEEF the next cycle.
- Store `cpu_wen` = 0100, `cpu_addr` = 0x80001000, `addr_ok` delayed 3 cycles: `data_req` is held high 4 cycles with `data_addr` = 0x80001002, `data_size` = 0, `data_wr` = 1, and the fields stay stable throughout.
- Load with `data_ok` 5 cycles after `addr_ok`, `cpu_stall_other` high 2 cycles after completion: exactly one bus request is issued, state stays DONE for 2 cycles, `cpu_stall` = 0 during DONE.
- Halfword store with `cpu_wen` = 1100: `data_size` = 1 and addr[1:0] = 2. With `cpu_wen` = 0000 and `cpu_en` = 0: no request is issued and stall stays 0.
- `rst` driven low while in WAIT_DATA: `data_req` = 0 and `cpu_rdata` = 0 immediately. After release, a spurious `data_ok` leaves the state IDLE.
- Two consecutive loads (0x1000, 0x1004) with 1-cycle slave latency: two distinct requests, separated by one cycle with `data_req` = 0, each returning its own rdata.
